// File: rtl/ram_sp_be_clear_if.sv
// Request/response bus for ram_sp_be_clear.
// A request transfers on a posedge where req_valid && req_ready; the response side has no backpressure.
interface ram_sp_be_clear_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_sp_be_clear.sv
// Single-port synchronous RAM with byte strobes, 1-cycle registered read response,
// out-of-range flagging and optional zero-fill of every word after reset.
module ram_sp_be_clear #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int DEPTH          = 65536,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    ram_sp_be_clear_if.slave     bus,
    output logic                 init_done,
    output logic [1:0]           dbg_state
);
    localparam int                  STRB_W   = DATA_WIDTH / 8;
    localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_CLEAR = 2'd1,
        S_IDLE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDX_W-1:0]      clr_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             in_range;
    logic             wr_en;
    logic             rd_en;
    logic             clr_en;
    logic [IDX_W-1:0] idx;

    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            S_CLEAR: if (clr_ptr == LAST_IDX) state_next = S_IDLE;
            S_IDLE:  state_next = S_IDLE;
            default: state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_RESET;
        else       state <= state_next;
    end

    // Pointer sits at 0 outside CLEAR, so any re-entry restarts the fill from word 0.
    always_ff @(posedge clk) begin
        if (reset || state != S_CLEAR) clr_ptr <= '0;
        else                           clr_ptr <= clr_ptr + IDX_W'(1);
    end

    // Ready is masked during a reset cycle so nothing is accepted while the block restarts.
    assign bus.req_ready = (state == S_IDLE) && !reset;
    assign init_done     = (state == S_IDLE);
    assign dbg_state     = state;

    assign accept   = bus.req_valid && bus.req_ready;
    assign in_range = {1'b0, bus.req_addr} < DEPTH_L;
    assign idx      = bus.req_addr[IDX_W-1:0];
    assign wr_en    = accept && bus.req_write && in_range;
    assign rd_en    = accept && !bus.req_write;
    assign clr_en   = (state == S_CLEAR) && !reset;

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (bus.req_wstrb[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    // Read data is held between responses; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= rd_en;
            bus.rsp_err   <= accept && !in_range;
            if (rd_en) bus.rsp_rdata <= in_range ? mem[idx] : '0;
        end
    end
endmodule

// File: tb/tb_ram_sp_be_clear.sv
// Directed bench for ram_sp_be_clear: one clearing instance and one non-clearing instance
// driven with identical stimulus; inputs change and outputs are sampled on the falling edge.
module tb_ram_sp_be_clear;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        init_done_c, init_done_k;
    logic [1:0]  dbg_state_c, dbg_state_k;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ram_sp_be_clear_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_c ();
    ram_sp_be_clear_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_k ();

    assign bus_c.req_valid = req_valid;
    assign bus_c.req_write = req_write;
    assign bus_c.req_addr  = req_addr;
    assign bus_c.req_wdata = req_wdata;
    assign bus_c.req_wstrb = req_wstrb;
    assign bus_k.req_valid = req_valid;
    assign bus_k.req_write = req_write;
    assign bus_k.req_addr  = req_addr;
    assign bus_k.req_wdata = req_wdata;
    assign bus_k.req_wstrb = req_wstrb;

    ram_sp_be_clear #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c), .init_done(init_done_c), .dbg_state(dbg_state_c)
    );

    ram_sp_be_clear #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .CLEAR_ON_RESET(1'b0)) dut_k (
        .clk(clk), .reset(reset), .bus(bus_k), .init_done(init_done_k), .dbg_state(dbg_state_k)
    );

    always @(posedge clk) begin
        if (!reset && bus_c.req_valid && bus_c.req_ready && bus_c.req_write && bus_c.req_addr < 5'd16)
            $display("RAM[%0d] <= %h/%h", bus_c.req_addr, bus_c.req_wdata, bus_c.req_wstrb);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_req(input logic w, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_c,
                          input logic chk_k, input logic [31:0] exp_k);
        logic [31:0] e;
        check("req_ready", 32'(bus_c.req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        if (!w) exp_q.push_back(exp_c);
        @(negedge clk);
        req_valid = 1'b0;
        check("rsp_valid", 32'(bus_c.rsp_valid), 32'(!w));
        check("rsp_err", 32'(bus_c.rsp_err), 32'(a >= 5'd16));
        if (!w) begin
            e = exp_q.pop_front();
            check("rsp_rdata", bus_c.rsp_rdata, e);
        end
        if (chk_k) begin
            check("k_rsp_valid", 32'(bus_k.rsp_valid), 32'(!w));
            check("k_rsp_rdata", bus_k.rsp_rdata, exp_k);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        do_req(1'b1, a, d, s, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e);
        do_req(1'b0, a, 32'd0, 4'd0, e, 1'b0, 32'd0);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_rsp_valid", 32'(bus_c.rsp_valid), 32'd0);
        check("idle_rsp_err", 32'(bus_c.rsp_err), 32'd0);
    endtask

    // Called right after reset drops; the clearing instance must stay not-ready for 16 cycles.
    task automatic wait_clear();
        int cnt  = 0;
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("k_ready_1cyc", 32'(bus_k.req_ready), 32'd1);
                check("k_init_done", 32'(init_done_k), 32'd1);
                check("c_init_done_low", 32'(init_done_c), 32'd0);
            end
            if (bus_c.req_ready) done = 1'b1;
            else cnt++;
        end
        check("clear_cycles", 32'(cnt), 32'd16);
        check("init_done", 32'(init_done_c), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", 32'(bus_c.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus_c.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus_c.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus_c.rsp_err), 32'd0);
        check("rst_init_done", 32'(init_done_c), 32'd0);

        reset = 1'b0;
        wait_clear();
        for (int a = 0; a < 16; a++) rd(5'(a), 32'd0);

        wr(5'd3, 32'hDEADBEEF, 4'hF);
        rd(5'd3, 32'hDEADBEEF);

        wr(5'd3, 32'h11223344, 4'b0101);
        rd(5'd3, 32'hDE22BE44);

        wr(5'd3, 32'hFFFFFFFF, 4'h0);
        rd(5'd3, 32'hDE22BE44);

        wr(5'd5, 32'hA5A5A5A5, 4'hF);
        rd(5'd5, 32'hA5A5A5A5);
        rd(5'd3, 32'hDE22BE44);
        idle();

        rd(5'd20, 32'd0);
        wr(5'd20, 32'h12345678, 4'hF);
        rd(5'd4, 32'd0);
        rd(5'd5, 32'hA5A5A5A5);
        idle();

        wr(5'd6, 32'h00000000, 4'hF);
        wr(5'd6, 32'hAABBCCDD, 4'b1000);
        rd(5'd6, 32'hAA000000);
        held = 32'hAA000000;
        idle();
        check("rdata_hold", bus_c.rsp_rdata, held);

        wr(5'd7, 32'hCAFEF00D, 4'hF);
        do_req(1'b0, 5'd7, 32'd0, 4'd0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);

        // A read presented in the reset cycle must never produce a response.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd7;
        reset     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("squash_rsp_valid", 32'(bus_c.rsp_valid), 32'd0);
        check("squash_k_rsp_valid", 32'(bus_k.rsp_valid), 32'd0);
        check("squash_rsp_rdata", bus_c.rsp_rdata, 32'd0);
        check("squash_req_ready", 32'(bus_c.req_ready), 32'd0);
        reset = 1'b0;
        wait_clear();
        do_req(1'b0, 5'd7, 32'd0, 4'd0, 32'd0, 1'b1, 32'hCAFEF00D);
        rd(5'd3, 32'd0);

        wr(5'd9, 32'h5A5A5A5A, 4'hF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("midclear_req_ready", 32'(bus_c.req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_clear();
        do_req(1'b0, 5'd9, 32'd0, 4'd0, 32'd0, 1'b1, 32'h5A5A5A5A);
        idle();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
